// File: rtl/adc_uart_pkg.sv
// Shared constants and FSM encoding for the ADC-to-UART sample FIFO.
package adc_uart_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 12;
  localparam int DROP_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2
  } state_t;
endpackage

// File: rtl/adc_uart_sdp_ram.sv
// Simple dual-port RAM: one write port, one read port with a registered,
// enable-held output. No reset on the array or the read register.
module adc_uart_sdp_ram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 12
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);
  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic [DATA_W-1:0] r_q;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_q <= r_mem[i_raddr];
  end

  assign o_rdata = r_q;
endmodule

// File: rtl/adc_uart_frame_fifo.sv
// FWFT sample FIFO with occupancy flags, drop accounting and armed frame capture.
// The RAM read register doubles as the output register; r_rd_valid qualifies it.
module adc_uart_frame_fifo
  import adc_uart_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int AFULL_LVL = 3584
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_frame_mode,
  input  logic [ADDR_W:0]       i_frame_len,
  input  logic                  i_arm,
  input  logic                  i_wr_valid,
  input  logic [DATA_W-1:0]     i_wr_data,
  output logic                  o_wr_ready,
  output logic                  o_rd_valid,
  output logic [DATA_W-1:0]     o_rd_data,
  input  logic                  i_rd_ready,
  output logic [ADDR_W:0]       o_count,
  output logic                  o_empty,
  output logic                  o_full,
  output logic                  o_almost_full,
  output logic                  o_capturing,
  output logic                  o_frame_done,
  output logic                  o_overflow,
  output logic [DROP_CNT_W-1:0] o_drop_cnt
);
  localparam logic [ADDR_W:0] C_DEPTH = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] C_ONE   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] C_AFULL = (ADDR_W+1)'(AFULL_LVL);

  state_t                  r_state, w_state_nxt;
  logic [ADDR_W-1:0]       r_wr_ptr, r_rd_ptr;
  logic [ADDR_W:0]         r_count, w_count_nxt, r_left;
  logic                    r_rd_valid, r_full, r_empty, r_afull;
  logic                    r_overflow, r_frame_done;
  logic [DROP_CNT_W-1:0]   r_drop_cnt;
  logic                    w_frame, w_wr_ready, w_wr_acc, w_rd_acc, w_drop;
  logic                    w_arm_go, w_fetch, w_frame_end;
  logic [DATA_W-1:0]       w_ram_q;

  // Once a frame is armed the mode input is ignored until the FSM returns to IDLE.
  assign w_frame    = i_frame_mode || (r_state != IDLE);
  assign w_wr_ready = !r_full && (!w_frame || (r_state == CAPTURE));
  assign w_wr_acc   = i_wr_valid && w_wr_ready;
  assign w_rd_acc   = r_rd_valid && i_rd_ready;
  assign w_drop     = i_wr_valid && !w_wr_ready && (!w_frame || (r_state == CAPTURE));
  assign w_arm_go   = i_arm && i_frame_mode && (r_state == IDLE);

  // Prefetch whenever the output slot frees up and an unfetched entry sits in RAM.
  assign w_fetch = (!r_rd_valid || i_rd_ready) &&
                   (r_count > {{ADDR_W{1'b0}}, r_rd_valid});

  assign w_count_nxt = r_count + {{ADDR_W{1'b0}}, w_wr_acc}
                               - {{ADDR_W{1'b0}}, w_rd_acc};

  always_comb begin
    w_state_nxt = r_state;
    w_frame_end = 1'b0;
    case (r_state)
      IDLE:    if (w_arm_go) w_state_nxt = CAPTURE;
      CAPTURE: if ((w_wr_acc && (r_left == C_ONE)) || w_drop) begin
        w_state_nxt = DRAIN;
        w_frame_end = 1'b1;
      end
      DRAIN:   if (r_empty) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= IDLE;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_left       <= '0;
      r_rd_valid   <= 1'b0;
      r_full       <= 1'b0;
      r_empty      <= 1'b1;
      r_afull      <= 1'b0;
      r_overflow   <= 1'b0;
      r_frame_done <= 1'b0;
      r_drop_cnt   <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_count      <= w_count_nxt;
      r_full       <= (w_count_nxt == C_DEPTH);
      r_empty      <= (w_count_nxt == '0);
      r_afull      <= (w_count_nxt >= C_AFULL);
      r_frame_done <= w_frame_end;
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_fetch) begin
        r_rd_ptr   <= r_rd_ptr + 1'b1;
        r_rd_valid <= 1'b1;
      end else if (w_rd_acc) begin
        r_rd_valid <= 1'b0;
      end
      if (w_arm_go)
        r_left <= (i_frame_len == '0) ? C_DEPTH : i_frame_len;
      else if (w_wr_acc && (r_state == CAPTURE))
        r_left <= r_left - C_ONE;
      if (w_arm_go) begin
        r_overflow <= 1'b0;
        r_drop_cnt <= '0;
      end else if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + 1'b1;
      end
    end
  end

  adc_uart_sdp_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
    .i_clk   (i_clk),
    .i_we    (w_wr_acc),
    .i_waddr (r_wr_ptr),
    .i_wdata (i_wr_data),
    .i_re    (w_fetch),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_ram_q)
  );

  // Gate the RAM register so discarded or uninitialised contents never show.
  assign o_rd_data     = r_rd_valid ? w_ram_q : '0;
  assign o_rd_valid    = r_rd_valid;
  assign o_wr_ready    = w_wr_ready;
  assign o_count       = r_count;
  assign o_empty       = r_empty;
  assign o_full        = r_full;
  assign o_almost_full = r_afull;
  assign o_capturing   = (r_state == CAPTURE);
  assign o_frame_done  = r_frame_done;
  assign o_overflow    = r_overflow;
  assign o_drop_cnt    = r_drop_cnt;
endmodule
